mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates IF and M requesters onto one shared memory port, one transaction at a time.
// Latency: grant at request+1, ready one cycle after mem_ack; requests held until ready. Optional MEM_ARBITER_RR_EN selects round-robin ties.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_M} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       pick_m;
  logic       grant_if, grant_m, complete, abort;

`ifdef MEM_ARBITER_RR_EN
  // last_m = 1 when the most recent grant went to M; ties go to the other port.
  logic last_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_m <= 1'b0;
    else if (grant_m || grant_if)
      last_m <= grant_m;
  end

  assign pick_m = m_req && !(if_req && last_m);
`else
  assign pick_m = m_req;
`endif

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_m   = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_m) begin
          grant_m   = 1'b1;
          state_nxt = GNT_M;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = GNT_IF;
        end
      end
      GNT_IF, GNT_M: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (mem_ack) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TMO) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      m_rdata   <= 32'h0;
      if_ready  <= 1'b0;
      m_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_ready <= 1'b0;
      m_ready  <= 1'b0;
      if (grant_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        cnt      <= 8'd1;
      end else if (grant_m) begin
        mem_req   <= 1'b1;
        mem_we    <= m_we;
        mem_addr  <= m_addr;
        mem_wdata <= m_wdata;
        cnt       <= 8'd1;
      end else if (complete || abort) begin
        mem_req <= 1'b0;
        cnt     <= 8'd0;
        if (abort)
          err <= 1'b1;
        if (state == GNT_IF) begin
          if_ready <= 1'b1;
          if_rdata <= complete ? mem_rdata : 32'h0;
        end else begin
          m_ready <= 1'b1;
          if (abort)
            m_rdata <= 32'h0;
          else if (!mem_we)
            m_rdata <= mem_rdata;
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
